// File: rtl/alu_arbiter_pkg.sv
// Shared types for the two-requester ALU arbiter: the ALU operation code
// and the arbiter FSM state encoding. Imported by Alu and alu_arbiter.
package types;

  // ALU operation codes presented by each requester.
  typedef enum logic [2:0] {
    ALU_ADD   = 3'd0,
    ALU_SUB   = 3'd1,
    ALU_AND   = 3'd2,
    ALU_OR    = 3'd3,
    ALU_XOR   = 3'd4,
    ALU_SLL   = 3'd5,
    ALU_SRL   = 3'd6,
    ALU_PASSA = 3'd7
  } AluOp;

  // Output register occupancy: IDLE means empty, FULL means a result is held.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_FULL = 1'b1
  } arb_state_t;

endpackage

// File: rtl/alu_arbiter_alu.sv
// Alu: purely combinational WIDTH-bit ALU shared by both requesters.
// Shifts use the low log2(WIDTH) bits of i_B as the shift amount.
module Alu
  import types::*;
#(
  parameter int WIDTH = 32
) (
  input  AluOp             i_Op,
  input  logic [WIDTH-1:0] i_A,
  input  logic [WIDTH-1:0] i_B,
  output logic [WIDTH-1:0] o_Y
);

  localparam int SHW = $clog2(WIDTH);

  logic [SHW-1:0] w_shamt;

  assign w_shamt = i_B[SHW-1:0];

  // Evaluate the selected operation.
  always_comb begin
    // NOTE: every signal written in always_comb gets a default first, so no path leaves it unassigned and infers a latch.
    o_Y = '0;
    case (i_Op)
      ALU_ADD:   o_Y = i_A + i_B;
      ALU_SUB:   o_Y = i_A - i_B;
      ALU_AND:   o_Y = i_A & i_B;
      ALU_OR:    o_Y = i_A | i_B;
      ALU_XOR:   o_Y = i_A ^ i_B;
      ALU_SLL:   o_Y = i_A << w_shamt;
      ALU_SRL:   o_Y = i_A >> w_shamt;
      ALU_PASSA: o_Y = i_A;
      default:   o_Y = '0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: two requesters share one combinational ALU; the result is
// captured in a one-entry output register with a valid/ready handshake.
// Grant-to-valid latency is one cycle; throughput one op per cycle.
// Build option ALU_ARBITER_FIXED_PRIO_EN: requester 0 always wins and the
// round-robin pointer is removed. Default build is round-robin.
module alu_arbiter
  import types::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  i_Clock,
  input  logic                  i_Reset,
  input  logic                  i_Req0,
  input  logic                  i_Req1,
  input  AluOp                  i_Op0,
  input  AluOp                  i_Op1,
  input  logic [DATA_WIDTH-1:0] i_DataA0,
  input  logic [DATA_WIDTH-1:0] i_DataB0,
  input  logic [DATA_WIDTH-1:0] i_DataA1,
  input  logic [DATA_WIDTH-1:0] i_DataB1,
  output logic                  o_Grant0,
  output logic                  o_Grant1,
  output logic                  o_ResultValid,
  output logic [DATA_WIDTH-1:0] o_Result,
  output logic                  o_ResultId,
  input  logic                  i_ResultReady
);

  arb_state_t            r_state;
  arb_state_t            w_next_state;
  logic                  w_sel;
  logic                  w_grant;
  AluOp                  w_op;
  logic [DATA_WIDTH-1:0] w_a;
  logic [DATA_WIDTH-1:0] w_b;
  logic [DATA_WIDTH-1:0] w_alu_y;
  logic [DATA_WIDTH-1:0] r_result;
  logic                  r_result_id;

`ifndef ALU_ARBITER_FIXED_PRIO_EN
  logic                  r_ptr;
`endif

  // Pick the requester that would be granted this cycle.
  always_comb begin
    w_sel = 1'b0;
`ifdef ALU_ARBITER_FIXED_PRIO_EN
    w_sel = ~i_Req0;
`else
    if (i_Req0 && i_Req1) begin
      w_sel = r_ptr;
    end else begin
      w_sel = i_Req1;
    end
`endif
  end

  // Grant decision and next state; a grant needs a free or draining output
  // register, and reset suppresses it combinationally.
  always_comb begin
    w_next_state = r_state;
    w_grant      = 1'b0;
    if (i_Reset && (i_Req0 || i_Req1) &&
        ((r_state == ST_IDLE) || i_ResultReady)) begin
      w_grant = 1'b1;
    end
    case (r_state)
      ST_IDLE: if (w_grant) w_next_state = ST_FULL;
      ST_FULL: if (i_ResultReady && !w_grant) w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
    o_Grant0 = w_grant & ~w_sel;
    o_Grant1 = w_grant &  w_sel;
  end

  // Steer the granted requester's operation and operands into the ALU.
  always_comb begin
    w_op = w_sel ? i_Op1    : i_Op0;
    w_a  = w_sel ? i_DataA1 : i_DataA0;
    w_b  = w_sel ? i_DataB1 : i_DataB0;
  end

  Alu #(
    .WIDTH (DATA_WIDTH)
  ) u_alu (
    .i_Op (w_op),
    .i_A  (w_a),
    .i_B  (w_b),
    .o_Y  (w_alu_y)
  );

  // FSM state register.
  always_ff @(posedge i_Clock or negedge i_Reset) begin
    // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
    if (!i_Reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Output register: capture ALU result and owner on every grant.
  always_ff @(posedge i_Clock or negedge i_Reset) begin
    if (!i_Reset) begin
      r_result    <= '0;
      r_result_id <= 1'b0;
    end else if (w_grant) begin
      r_result    <= w_alu_y;
      r_result_id <= w_sel;
    end
  end

`ifndef ALU_ARBITER_FIXED_PRIO_EN
  // Round-robin pointer: prefer the other requester after every grant.
  always_ff @(posedge i_Clock or negedge i_Reset) begin
    if (!i_Reset) begin
      r_ptr <= 1'b0;
    end else if (w_grant) begin
      r_ptr <= ~w_sel;
    end
  end
`endif

  assign o_ResultValid = (r_state == ST_FULL);
  assign o_Result      = r_result;
  assign o_ResultId    = r_result_id;

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: the driver applies directed vectors and
// pushes the hand-computed {id, result} of each expected grant; a monitor
// compares the held output against the queue head on every valid cycle and
// pops it when the consumer takes it.
module tb_alu_arbiter;
  import types::*;

  localparam int DW = 32;

  logic          i_Clock;
  logic          i_Reset;
  logic          i_Req0;
  logic          i_Req1;
  AluOp          i_Op0;
  AluOp          i_Op1;
  logic [DW-1:0] i_DataA0;
  logic [DW-1:0] i_DataB0;
  logic [DW-1:0] i_DataA1;
  logic [DW-1:0] i_DataB1;
  logic          o_Grant0;
  logic          o_Grant1;
  logic          o_ResultValid;
  logic [DW-1:0] o_Result;
  logic          o_ResultId;
  logic          i_ResultReady;

  int n_checks = 0;
  int n_errors = 0;
  logic [DW:0] sb_q[$];

  alu_arbiter #(
    .DATA_WIDTH (DW)
  ) dut (
    .i_Clock       (i_Clock),
    .i_Reset       (i_Reset),
    .i_Req0        (i_Req0),
    .i_Req1        (i_Req1),
    .i_Op0         (i_Op0),
    .i_Op1         (i_Op1),
    .i_DataA0      (i_DataA0),
    .i_DataB0      (i_DataB0),
    .i_DataA1      (i_DataA1),
    .i_DataB1      (i_DataB1),
    .o_Grant0      (o_Grant0),
    .o_Grant1      (o_Grant1),
    .o_ResultValid (o_ResultValid),
    .o_Result      (o_Result),
    .o_ResultId    (o_ResultId),
    .i_ResultReady (i_ResultReady)
  );

  initial i_Clock = 1'b0;
  always #5 i_Clock = ~i_Clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: held result must match the oldest outstanding expectation.
  always @(negedge i_Clock) begin
    if (i_Reset && o_ResultValid) begin
      if (sb_q.size() == 0) begin
        check("sb_underflow", 64'(sb_q.size()), 64'd1);
      end else begin
        check("result", 64'({o_ResultId, o_Result}), 64'(sb_q[0]));
        if (i_ResultReady) void'(sb_q.pop_front());
      end
    end
  end

  // One cycle of stimulus, starting just after a rising edge.
  task automatic step(input logic r0, input AluOp op0, input logic [DW-1:0] a0, input logic [DW-1:0] b0,
                      input logic r1, input AluOp op1, input logic [DW-1:0] a1, input logic [DW-1:0] b1,
                      input logic rdy, input logic eg0, input logic eg1, input logic ev,
                      input logic [DW-1:0] eres);
    i_Req0 = r0; i_Op0 = op0; i_DataA0 = a0; i_DataB0 = b0;
    i_Req1 = r1; i_Op1 = op1; i_DataA1 = a1; i_DataB1 = b1;
    i_ResultReady = rdy;
    if (eg0) sb_q.push_back({1'b0, eres});
    if (eg1) sb_q.push_back({1'b1, eres});
    @(negedge i_Clock);
    check("grant0", 64'(o_Grant0), 64'(eg0));
    check("grant1", 64'(o_Grant1), 64'(eg1));
    check("valid", 64'(o_ResultValid), 64'(ev));
    @(posedge i_Clock);
    #1;
  endtask

  task automatic idle(input logic rdy, input logic ev);
    step(1'b0, ALU_ADD, '0, '0, 1'b0, ALU_ADD, '0, '0, rdy, 1'b0, 1'b0, ev, '0);
  endtask

  task automatic req0(input AluOp op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                      input logic ev, input logic [DW-1:0] eres);
    step(1'b1, op, a, b, 1'b0, ALU_ADD, '0, '0, 1'b1, 1'b1, 1'b0, ev, eres);
  endtask

  task automatic req1(input AluOp op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                      input logic rdy, input logic eg1, input logic ev, input logic [DW-1:0] eres);
    step(1'b0, ALU_ADD, '0, '0, 1'b1, op, a, b, rdy, 1'b0, eg1, ev, eres);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] exp_rr[4];
    logic          exp_g1[4];

    // Reset held with a request present: everything cleared, no grant.
    i_Reset = 1'b0;
    i_Req0 = 1'b1; i_Req1 = 1'b0; i_Op0 = ALU_ADD; i_Op1 = ALU_ADD;
    i_DataA0 = '0; i_DataB0 = '0; i_DataA1 = '0; i_DataB1 = '0;
    i_ResultReady = 1'b0;
    #3;
    check("rst_valid", 64'(o_ResultValid), 64'd0);
    check("rst_result", 64'(o_Result), 64'd0);
    check("rst_id", 64'(o_ResultId), 64'd0);
    check("rst_grant0", 64'(o_Grant0), 64'd0);
    @(posedge i_Clock);
    #1;
    i_Reset = 1'b1;

    // Ready while idle with no request changes nothing.
    idle(1'b1, 1'b0);
    idle(1'b1, 1'b0);

    // Both requesting for four cycles: req0 ADD k+10, req1 SUB 100-k.
`ifdef ALU_ARBITER_FIXED_PRIO_EN
    exp_rr = '{32'd10, 32'd11, 32'd12, 32'd13};
    exp_g1 = '{1'b0, 1'b0, 1'b0, 1'b0};
`else
    exp_rr = '{32'd10, 32'd99, 32'd12, 32'd97};
    exp_g1 = '{1'b0, 1'b1, 1'b0, 1'b1};
`endif
    for (int k = 0; k < 4; k++) begin
      step(1'b1, ALU_ADD, DW'(k), 32'd10, 1'b1, ALU_SUB, 32'd100, DW'(k), 1'b1,
           ~exp_g1[k], exp_g1[k], (k != 0), exp_rr[k]);
    end
    idle(1'b1, 1'b1);
    idle(1'b1, 1'b0);

    // Single request: ADD 5+7, valid next cycle, idle after.
    req0(ALU_ADD, 32'd5, 32'd7, 1'b0, 32'd12);
    idle(1'b1, 1'b1);
    idle(1'b1, 1'b0);

    // Held result under backpressure with req1 pending, then released.
    req0(ALU_AND, 32'h0000_F0F0, 32'h0000_FF00, 1'b0, 32'h0000_F000);
    for (int k = 0; k < 3; k++) req1(ALU_ADD, 32'd3, 32'd4, 1'b0, 1'b0, 1'b1, '0);
    req1(ALU_ADD, 32'd3, 32'd4, 1'b1, 1'b1, 1'b1, 32'd7);
    idle(1'b1, 1'b1);
    idle(1'b1, 1'b0);

    // Back-to-back req1 SUBs, valid stays high.
    req1(ALU_SUB, 32'd10, 32'd3, 1'b1, 1'b1, 1'b0, 32'd7);
    req1(ALU_SUB, 32'd20, 32'd4, 1'b1, 1'b1, 1'b1, 32'd16);
    idle(1'b1, 1'b1);
    idle(1'b1, 1'b0);

    // Remaining operations and wrap-around boundaries, streamed.
    req0(ALU_ADD,   32'hFFFF_FFFF, 32'd1,  1'b0, 32'd0);
    req0(ALU_SUB,   32'd0,         32'd1,  1'b1, 32'hFFFF_FFFF);
    req0(ALU_OR,    32'h0F,        32'h30, 1'b1, 32'h3F);
    req0(ALU_XOR,   32'hFF,        32'h0F, 1'b1, 32'hF0);
    req0(ALU_SLL,   32'd1,         32'd4,  1'b1, 32'h10);
    req0(ALU_SRL,   32'h80,        32'd3,  1'b1, 32'h10);
    req0(ALU_PASSA, 32'h1234_5678, 32'd9,  1'b1, 32'h1234_5678);
    idle(1'b1, 1'b1);
    idle(1'b1, 1'b0);

    // Asynchronous reset while FULL clears outputs before the next edge.
    req0(ALU_ADD, 32'd1, 32'd2, 1'b0, 32'd3);
    i_Req0 = 1'b1; i_Req1 = 1'b0; i_ResultReady = 1'b0;
    #2;
    check("full_before_rst", 64'(o_ResultValid), 64'd1);
    i_Reset = 1'b0;
    #1;
    check("arst_valid", 64'(o_ResultValid), 64'd0);
    check("arst_result", 64'(o_Result), 64'd0);
    check("arst_id", 64'(o_ResultId), 64'd0);
    check("arst_grant0", 64'(o_Grant0), 64'd0);
    sb_q.delete();
    @(posedge i_Clock);
    #1;
    i_Reset = 1'b1;
    step(1'b1, ALU_ADD, 32'd4, 32'd4, 1'b1, ALU_SUB, 32'd9, 32'd1, 1'b1,
         1'b1, 1'b0, 1'b0, 32'd8);
    idle(1'b1, 1'b1);
    idle(1'b1, 1'b0);

    check("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
